// File: rtl/cb_module.sv
// Connection block: 69-bit serial configuration chain selecting 16 outputs
// from a 16-bit routing-track pool, gated by per-port and global enables.
module cb_module (
    input  logic       rst,
    input  logic       prog_clk,
    input  logic       clb_clk,
    input  logic       prog_en,
    input  logic       prog_in,
    output logic       prog_out,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    input  logic [3:0] in4,
    output logic [3:0] out1,
    output logic [3:0] out2,
    output logic [3:0] out3,
    output logic [3:0] out4
);

    logic [68:0] cfg;
    logic [15:0] pool;
    logic [15:0] opool;

    // clb_clk exists only for tile-interface compatibility
    logic unused_clb_clk;
    assign unused_clb_clk = clb_clk;

    always_ff @(posedge prog_clk or negedge rst) begin
        if (!rst) begin
            cfg <= '0;
        end else if (prog_en) begin
            cfg <= {prog_in, cfg[68:1]};
        end
    end

    assign prog_out = cfg[0];
    assign pool     = {in4, in3, in2, in1};

    // Outputs are forced low while shifting so partial configs never leak
    always_comb begin
        opool = '0;
        for (int unsigned j = 0; j < 16; j++) begin
            opool[j] = pool[cfg[4*j +: 4]] & cfg[64 + j/4] & cfg[68] & ~prog_en;
        end
    end

    assign {out4, out3, out2, out1} = opool;

endmodule

// File: tb/tb_cb_module.sv
// Self-checking bench for cb_module: table-driven programming vectors plus
// directed reset / hold / shift-gating sequences and a random-load model check.
module tb_cb_module;

    logic       rst;
    logic       prog_clk;
    logic       clb_clk;
    logic       prog_en;
    logic       prog_in;
    logic       prog_out;
    logic [3:0] in1, in2, in3, in4;
    logic [3:0] out1, out2, out3, out4;

    int checks   = 0;
    int failures = 0;

    cb_module dut (
        .rst      (rst),
        .prog_clk (prog_clk),
        .clb_clk  (clb_clk),
        .prog_en  (prog_en),
        .prog_in  (prog_in),
        .prog_out (prog_out),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .in4      (in4),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .out4     (out4)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;
    initial clb_clk = 1'b0;
    always #7 clb_clk = ~clb_clk;

    typedef struct {
        string       name;
        logic [68:0] cfg_val;
        logic [15:0] pool_in;
        logic [15:0] expected;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [15:0] outs();
        return {out4, out3, out2, out1};
    endfunction

    task automatic set_pool(input logic [15:0] p);
        {in4, in3, in2, in1} = p;
    endtask

    // mode: 0 sel_j=j, 1 all sel=0, 2 sel_j=15-j, 3 all sel=15
    function automatic logic [68:0] make_cfg(input int mode, input logic [4:0] en);
        logic [68:0] c;
        c = '0;
        for (int j = 0; j < 16; j++) begin
            case (mode)
                0:       c[4*j +: 4] = 4'(j);
                1:       c[4*j +: 4] = 4'd0;
                2:       c[4*j +: 4] = 4'(15 - j);
                default: c[4*j +: 4] = 4'd15;
            endcase
        end
        c[68:64] = en;
        return c;
    endfunction

    function automatic logic [15:0] model(input logic [68:0] c, input logic [15:0] p, input logic pe);
        logic [15:0] o;
        o = '0;
        for (int j = 0; j < 16; j++) begin
            logic [3:0] s;
            s = c[4*j +: 4];
            o[j] = p[s] & c[64 + j/4] & c[68] & ~pe;
        end
        return o;
    endfunction

    // Shifts n bits of v (bit k on edge k); prog_en is left high afterwards.
    task automatic shift_bits(input logic [68:0] v, input int n);
        prog_en = 1'b1;
        for (int k = 0; k < n; k++) begin
            prog_in = v[k];
            @(posedge prog_clk);
            #1;
        end
    endtask

    task automatic program_cfg(input logic [68:0] v);
        shift_bits(v, 69);
        prog_en = 1'b0;
        prog_in = 1'b0;
        #1;
    endtask

    initial begin
        logic [68:0] rcfg;
        logic [15:0] rp;

        vecs[0] = '{"ident_a5c3",  make_cfg(0, 5'b11111), 16'hA5C3, 16'hA5C3};
        vecs[1] = '{"ident_1234",  make_cfg(0, 5'b11111), 16'h1234, 16'h1234};
        vecs[2] = '{"global_off",  make_cfg(0, 5'b01111), 16'hFFFF, 16'h0000};
        vecs[3] = '{"out2_only_f", make_cfg(0, 5'b10010), 16'hFFFF, 16'h00F0};
        vecs[4] = '{"out2_only_a", make_cfg(0, 5'b10010), 16'hA5C3, 16'h00C0};
        vecs[5] = '{"fanout_one",  make_cfg(1, 5'b11111), 16'h0001, 16'hFFFF};
        vecs[6] = '{"fanout_zero", make_cfg(1, 5'b11111), 16'hFFFE, 16'h0000};
        vecs[7] = '{"reverse_1",   make_cfg(2, 5'b11111), 16'h0001, 16'h8000};
        vecs[8] = '{"reverse_a5",  make_cfg(2, 5'b11111), 16'hA5C3, 16'hC3A5};
        vecs[9] = '{"out4_out1",   make_cfg(0, 5'b11001), 16'hA5C3, 16'hA003};

        // Reset held while the chain is being clocked with prog_en=1
        rst = 1'b0;
        prog_en = 1'b1;
        prog_in = 1'b1;
        set_pool(16'hBEEF);
        #100;
        prog_en = 1'b0;
        #1;
        chk("reset_outs", 32'(outs()), 32'h0);
        chk("reset_prog_out", 32'(prog_out), 32'h0);
        rst = 1'b1;
        @(posedge prog_clk);
        #1;

        foreach (vecs[i]) begin
            set_pool(vecs[i].pool_in);
            shift_bits(vecs[i].cfg_val, 35);
            chk({vecs[i].name, "_midshift"}, 32'(outs()), 32'h0);
            shift_bits(vecs[i].cfg_val >> 35, 34);
            prog_en = 1'b0;
            #1;
            chk(vecs[i].name, 32'(outs()), 32'(vecs[i].expected));
            chk({vecs[i].name, "_prog_out"}, 32'(prog_out), 32'(vecs[i].cfg_val[0]));
        end

        // 69 ones: all selects = 15 (in4[3]), all enables on
        set_pool(16'h8000);
        program_cfg('1);
        chk("ones_prog_out", 32'(prog_out), 32'h1);
        chk("ones_outs", 32'(outs()), 32'hFFFF);
        prog_in = 1'b0;
        repeat (5) @(posedge prog_clk);
        #1;
        chk("hold_prog_out", 32'(prog_out), 32'h1);
        chk("hold_outs", 32'(outs()), 32'hFFFF);
        set_pool(16'h7FFF);
        #1;
        chk("hold_outs_in_change", 32'(outs()), 32'h0000);
        set_pool(16'h8000);
        prog_en = 1'b1;
        #1;
        chk("prog_en_gates", 32'(outs()), 32'h0);
        prog_en = 1'b0;
        #1;
        chk("prog_en_release", 32'(outs()), 32'hFFFF);

        // Reset mid-programming: 30 zeros leave cfg[0]=1 until reset hits
        shift_bits('0, 30);
        chk("partial_prog_out", 32'(prog_out), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_prog_out", 32'(prog_out), 32'h0);
        prog_en = 1'b0;
        #1;
        chk("midreset_outs", 32'(outs()), 32'h0);
        #3;
        rst = 1'b1;
        @(posedge prog_clk);
        #1;
        chk("post_release_prog_out", 32'(prog_out), 32'h0);

        // Random load checked against the reference model
        rcfg = {$urandom, $urandom, $urandom};
        rcfg[68:64] = 5'b11111;
        program_cfg(rcfg);
        chk("rand_prog_out", 32'(prog_out), 32'(rcfg[0]));
        for (int t = 0; t < 8; t++) begin
            rp = 16'($urandom);
            set_pool(rp);
            #1;
            chk("rand_model", 32'(outs()), 32'(model(rcfg, rp, 1'b0)));
        end
        rcfg = {$urandom, $urandom, $urandom};
        program_cfg(rcfg);
        for (int t = 0; t < 4; t++) begin
            rp = 16'($urandom);
            set_pool(rp);
            #1;
            chk("rand2_model", 32'(outs()), 32'(model(rcfg, rp, 1'b0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
